// File: rtl/acorn128_stream_out.sv
// Output stage for the ACORN-128 core: captures results on core completion and
// streams ciphertext+tag (encrypt) or tag-verified plaintext (decrypt) as words.
module acorn128_stream_out #(
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_ready_in,
    input  logic              encrypt_in,
    input  logic [127:0]      ciphertext_in,
    input  logic [127:0]      plaintext_in,
    input  logic [127:0]      tag_in,
    input  logic [127:0]      expected_tag_in,
    output logic [WORD_W-1:0] m_data_out,
    output logic              m_valid_out,
    output logic              m_last_out,
    input  logic              m_ready_in,
    output logic              tag_ok_out,
    output logic              tag_fail_out,
    output logic              busy_out,
    output logic              overrun_out
);

    localparam int unsigned ENC_WORDS = 256 / WORD_W;
    localparam int unsigned DEC_WORDS = 128 / WORD_W;
    localparam int unsigned CW        = $clog2(ENC_WORDS) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           ready_q;
    logic [255:0]   buffer;
    logic [127:0]   tag_calc;
    logic [127:0]   tag_exp;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  last_idx;
    logic           capture;
    logic           handshake;
    logic           is_last;
    logic           tags_eq;

    assign capture     = core_ready_in & ~ready_q;
    assign m_valid_out = (state_q == SEND);
    assign handshake   = m_valid_out & m_ready_in;
    assign is_last     = (cnt == last_idx);
    assign tags_eq     = (tag_calc == tag_exp);
    assign m_data_out  = m_valid_out ? buffer[255 -: WORD_W] : '0;
    assign m_last_out  = m_valid_out & is_last;
    assign busy_out    = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture) state_d = encrypt_in ? SEND : CHECK;
            CHECK:   state_d = tags_eq ? SEND : IDLE;
            SEND:    if (handshake && is_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q      <= 1'b0;
            buffer       <= '0;
            tag_calc     <= '0;
            tag_exp      <= '0;
            cnt          <= '0;
            last_idx     <= '0;
            tag_ok_out   <= 1'b0;
            tag_fail_out <= 1'b0;
            overrun_out  <= 1'b0;
        end else begin
            ready_q      <= core_ready_in;
            tag_ok_out   <= 1'b0;
            tag_fail_out <= 1'b0;
            // Completion while busy is dropped; only the sticky flag records it.
            if (capture && state_q != IDLE) overrun_out <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        cnt <= '0;
                        if (encrypt_in) begin
                            buffer   <= {ciphertext_in, tag_in};
                            last_idx <= CW'(ENC_WORDS - 1);
                        end else begin
                            buffer   <= {plaintext_in, 128'd0};
                            tag_calc <= tag_in;
                            tag_exp  <= expected_tag_in;
                            last_idx <= CW'(DEC_WORDS - 1);
                        end
                    end
                end
                CHECK: begin
                    cnt <= '0;
                    if (tags_eq) begin
                        tag_ok_out <= 1'b1;
                    end else begin
                        tag_fail_out <= 1'b1;
                        buffer       <= '0;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        if (is_last) begin
                            buffer <= '0;
                        end else begin
                            buffer <= buffer << WORD_W;
                            cnt    <= cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acorn128_stream_out.sv
// Scoreboard bench for acorn128_stream_out: directed test-plan vectors plus
// randomized encrypt/decrypt messages under random backpressure.
module tb_acorn128_stream_out;

    localparam int unsigned W = 32;

    logic           clk;
    logic           rst_n;
    logic           core_ready_in;
    logic           encrypt_in;
    logic [127:0]   ciphertext_in;
    logic [127:0]   plaintext_in;
    logic [127:0]   tag_in;
    logic [127:0]   expected_tag_in;
    logic [W-1:0]   m_data_out;
    logic           m_valid_out;
    logic           m_last_out;
    logic           m_ready_in;
    logic           tag_ok_out;
    logic           tag_fail_out;
    logic           busy_out;
    logic           overrun_out;

    acorn128_stream_out #(.WORD_W(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .core_ready_in   (core_ready_in),
        .encrypt_in      (encrypt_in),
        .ciphertext_in   (ciphertext_in),
        .plaintext_in    (plaintext_in),
        .tag_in          (tag_in),
        .expected_tag_in (expected_tag_in),
        .m_data_out      (m_data_out),
        .m_valid_out     (m_valid_out),
        .m_last_out      (m_last_out),
        .m_ready_in      (m_ready_in),
        .tag_ok_out      (tag_ok_out),
        .tag_fail_out    (tag_fail_out),
        .busy_out        (busy_out),
        .overrun_out     (overrun_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned hs_count = 0;
    int unsigned rdy_mode = 0;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } word_t;

    word_t exp_q[$];
    bit    ev_q[$];

    task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    endtask

    // Sink ready: 0 = always ready, 1 = random, 2 = pattern 1,0,0
    initial begin
        int unsigned ph;
        ph = 0;
        m_ready_in = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       m_ready_in = 1'b1;
                1:       m_ready_in = ($urandom_range(0, 3) != 0);
                default: begin m_ready_in = (ph == 0); ph = (ph + 1) % 3; end
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    initial begin
        bit           stall_prev;
        logic [W-1:0] held_data;
        logic         held_last;
        word_t        w;
        stall_prev = 1'b0;
        held_data  = '0;
        held_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (m_valid_out) begin
                    if (stall_prev) begin
                        check(m_data_out == held_data, "stall_data", m_data_out, held_data);
                        check(m_last_out == held_last, "stall_last", m_last_out, held_last);
                    end
                    if (m_ready_in) begin
                        hs_count++;
                        if (exp_q.size() == 0) begin
                            check(1'b0, "unexpected_word", m_data_out, 0);
                        end else begin
                            w = exp_q.pop_front();
                            check(m_data_out == w.data, "word_data", m_data_out, w.data);
                            check(m_last_out == w.last, "word_last", m_last_out, w.last);
                        end
                    end
                    stall_prev = !m_ready_in;
                    held_data  = m_data_out;
                    held_last  = m_last_out;
                end else begin
                    stall_prev = 1'b0;
                    if (m_data_out != '0 || m_last_out)
                        check(1'b0, "idle_data_zero", {m_last_out, m_data_out}, 0);
                end
                if (tag_ok_out || tag_fail_out) begin
                    if (ev_q.size() == 0 || (tag_ok_out && tag_fail_out)) begin
                        check(1'b0, "unexpected_tag_pulse", {tag_ok_out, tag_fail_out}, 0);
                    end else begin
                        bit exp_ok;
                        exp_ok = ev_q.pop_front();
                        check(tag_ok_out == exp_ok, "tag_result", tag_ok_out, exp_ok);
                        check(m_valid_out == exp_ok, "valid_with_tag_pulse", m_valid_out, exp_ok);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int unsigned t;
        t = 0;
        while ((busy_out || exp_q.size() != 0) && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 2000) check(1'b0, "timeout_idle", busy_out, 0);
    endtask

    // Reference: the message is a bit string sent MSB-first in W-bit slices.
    task automatic issue(input bit enc, input logic [127:0] ct, input logic [127:0] pt,
                         input logic [127:0] tg, input logic [127:0] et, input bit timing);
        logic [255:0] msg;
        int unsigned  n;
        bit           match;
        word_t        w;
        wait_idle();
        match = (tg == et);
        msg   = enc ? {ct, tg} : {pt, 128'd0};
        n     = enc ? 256 / W : 128 / W;
        if (enc || match) begin
            for (int unsigned i = 0; i < n; i++) begin
                w.data = W'(msg >> (256 - W * (i + 1)));
                w.last = (i == n - 1);
                exp_q.push_back(w);
            end
        end
        if (!enc) ev_q.push_back(match);
        @(posedge clk); #1;
        encrypt_in      = enc;
        ciphertext_in   = ct;
        plaintext_in    = pt;
        tag_in          = tg;
        expected_tag_in = et;
        core_ready_in   = 1'b1;
        @(posedge clk); #1;
        core_ready_in   = 1'b0;
        if (timing) begin
            if (enc) begin
                check(m_valid_out && busy_out, "enc_latency_valid", m_valid_out, 1);
            end else begin
                check(!m_valid_out && busy_out, "check_cycle", {m_valid_out, busy_out}, 1);
                @(posedge clk); #1;
                if (match) begin
                    check(tag_ok_out && m_valid_out, "tag_ok_k2", {tag_ok_out, m_valid_out}, 3);
                end else begin
                    check(tag_fail_out && !m_valid_out, "tag_fail_k2", {tag_fail_out, m_valid_out}, 2);
                    @(posedge clk); #1;
                    check(!busy_out && !m_valid_out, "fail_idle_k3", {busy_out, m_valid_out}, 0);
                end
            end
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [127:0] CT  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] TG  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] PT  = 128'h66666666_66666666_66666666_66666666;
    localparam logic [127:0] DTG = 128'h0123456789ABCDEF0123456789ABCDEF;

    initial begin
        int unsigned base;
        int unsigned t;
        rst_n           = 1'b0;
        core_ready_in   = 1'b0;
        encrypt_in      = 1'b0;
        ciphertext_in   = '0;
        plaintext_in    = '0;
        tag_in          = '0;
        expected_tag_in = '0;
        #1;
        check({m_valid_out, m_last_out, tag_ok_out, tag_fail_out, busy_out, overrun_out} == 6'b0,
              "reset_outputs", {m_valid_out, m_last_out, tag_ok_out, tag_fail_out, busy_out, overrun_out}, 0);
        check(m_data_out == '0, "reset_data", m_data_out, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Encrypt at full throughput, with per-cycle busy timing
        rdy_mode = 0;
        issue(1'b1, CT, '0, TG, '0, 1'b1);
        repeat (7) begin
            @(posedge clk); #1;
            check(busy_out && m_valid_out, "enc_streaming", {busy_out, m_valid_out}, 3);
        end
        @(posedge clk); #1;
        check(!busy_out, "enc_busy_falls", busy_out, 0);
        check(exp_q.size() == 0, "enc_all_words", exp_q.size(), 0);

        // Backpressure 1,0,0
        rdy_mode = 2;
        base = hs_count;
        issue(1'b1, CT, '0, TG, '0, 1'b1);
        wait_idle();
        check(hs_count - base == 8, "bp_handshakes", hs_count - base, 8);

        // Decrypt match and bit-0 mismatch
        rdy_mode = 0;
        issue(1'b0, '0, PT, DTG, DTG, 1'b1);
        wait_idle();
        base = hs_count;
        issue(1'b0, '0, PT, DTG, DTG ^ 128'd1, 1'b1);
        wait_idle();
        check(hs_count == base, "mismatch_no_words", hs_count - base, 0);

        // Overrun during SEND
        rdy_mode = 2;
        check(!overrun_out, "overrun_clear", overrun_out, 0);
        issue(1'b1, CT, '0, TG, '0, 1'b0);
        @(posedge clk); #1;
        ciphertext_in = rnd128();
        core_ready_in = 1'b1;
        @(posedge clk); #1;
        core_ready_in = 1'b0;
        check(overrun_out, "overrun_set", overrun_out, 1);
        wait_idle();
        repeat (4) @(posedge clk);
        #1;
        check(overrun_out && !busy_out, "overrun_sticky_no_capture", {overrun_out, busy_out}, 2);

        // Reset after the 3rd handshake
        rdy_mode = 0;
        base = hs_count;
        issue(1'b1, CT, '0, TG, '0, 1'b0);
        t = 0;
        while (hs_count < base + 3 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check(1'b0, "timeout_3rd_hs", hs_count - base, 3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check({m_valid_out, m_last_out, tag_ok_out, tag_fail_out, busy_out, overrun_out} == 6'b0,
              "midstream_reset", {m_valid_out, m_last_out, tag_ok_out, tag_fail_out, busy_out, overrun_out}, 0);
        check(m_data_out == '0, "midstream_reset_data", m_data_out, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy_mode = 2;
        issue(1'b1, CT, '0, TG, '0, 1'b1);
        wait_idle();

        // Randomized messages
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            logic [127:0] tg;
            bit enc;
            bit bad;
            enc = $urandom_range(0, 1);
            bad = ($urandom_range(0, 3) == 0);
            tg  = rnd128();
            issue(enc, rnd128(), rnd128(), tg,
                  bad ? (tg ^ (128'd1 << $urandom_range(0, 127))) : tg, 1'b1);
        end
        wait_idle();
        repeat (3) @(posedge clk);
        check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
        check(ev_q.size() == 0, "tag_events_empty", ev_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
